// File: rtl/reverb_wet_dry_mixer_if.sv
// Dry, wet and mixed-output sample streams with valid/ready handshakes.
// Combinational bundle only; no latency. The slave side owns the readies and the output stream.
interface reverb_wet_dry_mixer_if #(
   parameter int G_DATA_WIDTH = 16
);
   logic signed [G_DATA_WIDTH-1:0] dry_din;
   logic                           dry_din_valid;
   logic                           dry_din_ready;
   logic signed [G_DATA_WIDTH-1:0] wet_din;
   logic                           wet_din_valid;
   logic                           wet_din_ready;
   logic signed [G_DATA_WIDTH-1:0] dout;
   logic                           dout_valid;
   logic                           dout_ready;

   modport master (
      output dry_din, dry_din_valid, wet_din, wet_din_valid, dout_ready,
      input  dry_din_ready, wet_din_ready, dout, dout_valid
   );

   modport slave (
      input  dry_din, dry_din_valid, wet_din, wet_din_valid, dout_ready,
      output dry_din_ready, wet_din_ready, dout, dout_valid
   );
endinterface

// File: rtl/reverb_wet_dry_mixer.sv
// Joins dry/wet streams, scales each by its gain, sums, rounds, saturates; REVERB_MIX_SAT_CNT_EN adds a clip counter.
// Latency: 3 cycles from accepted pair to dout_valid, throughput 1 sample/cycle.
// Backpressure: all stages stall together while dout_valid & !dout_ready; a lone input valid is never consumed.
module reverb_wet_dry_mixer #(
   parameter int G_DATA_WIDTH = 16,
   parameter int G_GAIN_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    bypass,
   input  logic [G_GAIN_WIDTH-1:0] dry_gain,
   input  logic [G_GAIN_WIDTH-1:0] wet_gain,
   reverb_wet_dry_mixer_if.slave   st,
   output logic [15:0]             sat_count
);
   localparam int W  = G_DATA_WIDTH;
   localparam int G  = G_GAIN_WIDTH;
   localparam int P  = W + G + 1;
   localparam int RW = W + 2;

   localparam logic signed [RW-1:0] MAX_V = {{(RW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [RW-1:0] MIN_V = {{(RW-W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic signed [P:0]    RND_V = {{(P+1-G){1'b0}}, 1'b1, {(G-1){1'b0}}};

   logic advance;
   logic accept;

   logic                  s1_vld_q, s1_vld_d;
   logic signed [P-1:0]   s1_pd_q, s1_pd_d;
   logic signed [P-1:0]   s1_pw_q, s1_pw_d;
   logic                  s1_byp_q, s1_byp_d;
   logic signed [W-1:0]   s1_dry_q, s1_dry_d;

   logic                  s2_vld_q, s2_vld_d;
   logic signed [RW-1:0]  s2_r_q, s2_r_d;
   logic                  s2_byp_q, s2_byp_d;
   logic signed [W-1:0]   s2_dry_q, s2_dry_d;

   logic                  dout_valid_q, dout_valid_d;
   logic signed [W-1:0]   dout_q, dout_d;

   logic signed [P-1:0]   pd;
   logic signed [P-1:0]   pw;
   logic signed [P:0]     sum;
   logic                  over;
   logic                  under;

   assign advance          = !dout_valid_q || st.dout_ready;
   assign accept           = st.dry_din_valid && st.wet_din_valid && advance && enable;
   assign st.dry_din_ready = st.wet_din_valid && advance && enable;
   assign st.wet_din_ready = st.dry_din_valid && advance && enable;
   assign st.dout          = dout_q;
   assign st.dout_valid    = dout_valid_q;

   // Operands are extended to the full product width so a truncated multiply is exact.
   assign pd    = {{(G+1){st.dry_din[W-1]}}, st.dry_din} * {{(W+1){1'b0}}, dry_gain};
   assign pw    = {{(G+1){st.wet_din[W-1]}}, st.wet_din} * {{(W+1){1'b0}}, wet_gain};
   assign sum   = {s1_pd_q[P-1], s1_pd_q} + {s1_pw_q[P-1], s1_pw_q} + RND_V;
   assign over  = s2_r_q > MAX_V;
   assign under = s2_r_q < MIN_V;

   always_comb begin
      s1_vld_d     = s1_vld_q;
      s1_pd_d      = s1_pd_q;
      s1_pw_d      = s1_pw_q;
      s1_byp_d     = s1_byp_q;
      s1_dry_d     = s1_dry_q;
      s2_vld_d     = s2_vld_q;
      s2_r_d       = s2_r_q;
      s2_byp_d     = s2_byp_q;
      s2_dry_d     = s2_dry_q;
      dout_valid_d = dout_valid_q;
      dout_d       = dout_q;
      if (!enable) begin
         s1_vld_d     = 1'b0;
         s2_vld_d     = 1'b0;
         dout_valid_d = 1'b0;
         dout_d       = '0;
      end else if (advance) begin
         s1_vld_d     = accept;
         s2_vld_d     = s1_vld_q;
         dout_valid_d = s2_vld_q;
         if (accept) begin
            s1_pd_d  = pd;
            s1_pw_d  = pw;
            s1_byp_d = bypass;
            s1_dry_d = st.dry_din;
         end
         if (s1_vld_q) begin
            s2_r_d   = RW'(sum >>> G);
            s2_byp_d = s1_byp_q;
            s2_dry_d = s1_dry_q;
         end
         if (s2_vld_q) begin
            if (s2_byp_q)   dout_d = s2_dry_q;
            else if (over)  dout_d = MAX_V[W-1:0];
            else if (under) dout_d = MIN_V[W-1:0];
            else            dout_d = s2_r_q[W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld_q     <= 1'b0;
         s1_pd_q      <= '0;
         s1_pw_q      <= '0;
         s1_byp_q     <= 1'b0;
         s1_dry_q     <= '0;
         s2_vld_q     <= 1'b0;
         s2_r_q       <= '0;
         s2_byp_q     <= 1'b0;
         s2_dry_q     <= '0;
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
      end else begin
         s1_vld_q     <= s1_vld_d;
         s1_pd_q      <= s1_pd_d;
         s1_pw_q      <= s1_pw_d;
         s1_byp_q     <= s1_byp_d;
         s1_dry_q     <= s1_dry_d;
         s2_vld_q     <= s2_vld_d;
         s2_r_q       <= s2_r_d;
         s2_byp_q     <= s2_byp_d;
         s2_dry_q     <= s2_dry_d;
         dout_valid_q <= dout_valid_d;
         dout_q       <= dout_d;
      end
   end

`ifdef REVERB_MIX_SAT_CNT_EN
   logic        clip_q, clip_d;
   logic [15:0] sat_q, sat_d;

   // The clip flag rides alongside dout; it is counted only once the sample leaves.
   always_comb begin
      clip_d = clip_q;
      sat_d  = sat_q;
      if (!enable) begin
         clip_d = 1'b0;
         sat_d  = '0;
      end else begin
         if (dout_valid_q && st.dout_ready && clip_q && (sat_q != 16'hFFFF))
            sat_d = sat_q + 16'd1;
         if (advance && s2_vld_q)
            clip_d = !s2_byp_q && (over || under);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clip_q <= 1'b0;
         sat_q  <= '0;
      end else begin
         clip_q <= clip_d;
         sat_q  <= sat_d;
      end
   end

   assign sat_count = sat_q;
`else
   assign sat_count = '0;
`endif
endmodule

// File: tb/tb_reverb_wet_dry_mixer.sv
// Bench for reverb_wet_dry_mixer: directed and random streams scored against an arithmetic reference model.
module tb_reverb_wet_dry_mixer;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        bypass;
   logic [15:0] dry_gain;
   logic [15:0] wet_gain;
   logic [15:0] sat_count;

   reverb_wet_dry_mixer_if #(.G_DATA_WIDTH(16)) ifc();

   reverb_wet_dry_mixer #(.G_DATA_WIDTH(16), .G_GAIN_WIDTH(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .bypass    (bypass),
      .dry_gain  (dry_gain),
      .wet_gain  (wet_gain),
      .st        (ifc),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int v;
      bit clip;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   out_cnt = 0;
   int   in_cnt = 0;
   int   sat_model = 0;
   int   last_dout = 0;
   int   prev_dout = 0;
   bit   prev_stall = 0;
   bit   prev_en = 0;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(int d, int w, int dg, int wg, bit byp);
      exp_t   e;
      longint s;
      if (byp) begin
         e.v = d;
         e.clip = 1'b0;
         return e;
      end
      s = (longint'(d) * dg + longint'(w) * wg + 64'sd32768) >>> 16;
      if (s > 32767) begin
         e.v = 32767;  e.clip = 1'b1;
      end else if (s < -32768) begin
         e.v = -32768; e.clip = 1'b1;
      end else begin
         e.v = int'(s); e.clip = 1'b0;
      end
      return e;
   endfunction

   // Inputs change 2 time units after a rising edge, so the falling edge sees stable values.
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
`ifdef REVERB_MIX_SAT_CNT_EN
         chk("sat_count", sat_count, sat_model);
`else
         chk("sat_count", sat_count, 0);
`endif
         if (prev_stall && prev_en) begin
            chk("hold_vld", ifc.dout_valid, 1);
            chk("hold_dat", ifc.dout, prev_dout);
         end
         chk("dry_rdy", ifc.dry_din_ready,
             ifc.wet_din_valid && enable && (!ifc.dout_valid || ifc.dout_ready));
         chk("wet_rdy", ifc.wet_din_ready,
             ifc.dry_din_valid && enable && (!ifc.dout_valid || ifc.dout_ready));
         if (ifc.dout_valid && ifc.dout_ready) begin
            out_cnt++;
            last_dout = ifc.dout;
            chk("out_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               mon_e = sb.pop_front();
               chk("dout", ifc.dout, mon_e.v);
               if (mon_e.clip && sat_model < 65535) sat_model++;
            end
         end
         if (ifc.dry_din_valid && ifc.wet_din_valid && ifc.dry_din_ready && ifc.wet_din_ready) begin
            in_cnt++;
            sb.push_back(model(ifc.dry_din, ifc.wet_din, dry_gain, wet_gain, bypass));
         end
         if (!enable) begin
            sb.delete();
            sat_model = 0;
         end
         prev_stall = ifc.dout_valid && !ifc.dout_ready;
         prev_dout  = ifc.dout;
         prev_en    = enable;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input int d, input int w, input int dg, input int wg, input bit byp);
      bit acc;
      int n;
      ifc.dry_din = 16'(d);
      ifc.wet_din = 16'(w);
      dry_gain = 16'(dg);
      wet_gain = 16'(wg);
      bypass = byp;
      ifc.dry_din_valid = 1'b1;
      ifc.wet_din_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         acc = ifc.dry_din_ready;
         cyc();
         n++;
      end while (!acc && n < 50);
      ifc.dry_din_valid = 1'b0;
      ifc.wet_din_valid = 1'b0;
      bypass = 1'b0;
      chk("send_accepted", acc, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin
         cyc();
         n++;
      end while ((sb.size() != 0 || ifc.dout_valid) && n < 60);
      chk("drain_empty", sb.size(), 0);
   endtask

   int cyc_n;
   int idx;
   int c;
   int c0;
   int i0;
   bit acc_r;

   initial begin
      reset_n = 1'b0;
      enable = 1'b1;
      bypass = 1'b0;
      dry_gain = '0;
      wet_gain = '0;
      ifc.dry_din = '0;
      ifc.wet_din = '0;
      ifc.dry_din_valid = 1'b0;
      ifc.wet_din_valid = 1'b0;
      ifc.dout_ready = 1'b1;
      #12;
      chk("rst_dout_valid", ifc.dout_valid, 0);
      chk("rst_dout", ifc.dout, 0);
      chk("rst_sat", sat_count, 0);
      cyc();
      reset_n = 1'b1;
      cyc();

      // Basic mix and first-sample latency.
      ifc.dry_din = 16'sd1000;
      ifc.wet_din = 16'sd2000;
      dry_gain = 16'h8000;
      wet_gain = 16'h8000;
      ifc.dry_din_valid = 1'b1;
      ifc.wet_din_valid = 1'b1;
      @(posedge clk);
      #1;
      ifc.dry_din_valid = 1'b0;
      ifc.wet_din_valid = 1'b0;
      cyc_n = 1;
      while (!ifc.dout_valid && cyc_n < 10) begin
         @(posedge clk);
         #1;
         cyc_n++;
      end
      chk("latency", cyc_n, 3);
      chk("mix_1500", ifc.dout, 1500);
      drain();

      // Saturation in both directions.
      send(32767, 32767, 16'hFFFF, 16'hFFFF, 1'b0);
      drain();
      chk("clip_pos", last_dout, 32767);
      send(-32768, -32768, 16'hFFFF, 16'hFFFF, 1'b0);
      drain();
      chk("clip_neg", last_dout, -32768);
`ifdef REVERB_MIX_SAT_CNT_EN
      chk("sat_two", sat_count, 2);
`else
      chk("sat_two", sat_count, 0);
`endif

      // Rounding half toward +inf.
      send(1, 0, 16'h8000, 16'h8000, 1'b0);
      drain();
      chk("round_pos", last_dout, 1);
      send(-1, 0, 16'h8000, 16'h8000, 1'b0);
      drain();
      chk("round_neg", last_dout, 0);

      // A lone dry valid must not be consumed.
      ifc.dry_din = 16'sd7;
      ifc.dry_din_valid = 1'b1;
      c0 = out_cnt;
      repeat (5) begin
         cyc();
         chk("lone_dry_rdy", ifc.dry_din_ready, 0);
         chk("lone_no_out", ifc.dout_valid, 0);
      end
      send(7, 3, 16'h8000, 16'h8000, 1'b0);
      drain();
      chk("lone_one_pair", out_cnt - c0, 1);
      chk("lone_value", last_dout, 5);

      // 20-sample ramp with a ten-cycle output stall.
      c0 = out_cnt;
      idx = 0;
      c = 0;
      dry_gain = 16'h8000;
      wet_gain = 16'h8000;
      while (idx < 20 && c < 200) begin
         ifc.dout_ready = !(c >= 4 && c <= 13);
         ifc.dry_din = 16'(idx * 100);
         ifc.wet_din = 16'(idx * 100);
         ifc.dry_din_valid = 1'b1;
         ifc.wet_din_valid = 1'b1;
         @(negedge clk);
         acc_r = ifc.dry_din_ready && ifc.wet_din_ready;
         cyc();
         if (acc_r) idx++;
         c++;
      end
      ifc.dry_din_valid = 1'b0;
      ifc.wet_din_valid = 1'b0;
      ifc.dout_ready = 1'b1;
      drain();
      chk("ramp_count", out_cnt - c0, 20);
      chk("ramp_last", last_dout, 1900);

      // Random traffic with random gains, bypass and backpressure.
      c0 = out_cnt;
      i0 = in_cnt;
      for (int k = 0; k < 400; k++) begin
         ifc.dry_din = 16'($urandom);
         ifc.wet_din = 16'($urandom);
         dry_gain = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
         wet_gain = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
         bypass = ($urandom_range(0, 9) == 0);
         ifc.dry_din_valid = ($urandom_range(0, 3) != 0);
         ifc.wet_din_valid = ($urandom_range(0, 3) != 0);
         ifc.dout_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      ifc.dry_din_valid = 1'b0;
      ifc.wet_din_valid = 1'b0;
      ifc.dout_ready = 1'b1;
      bypass = 1'b0;
      drain();
      chk("rnd_in_out", out_cnt - c0, in_cnt - i0);

      // Synchronous flush through enable.
      ifc.dout_ready = 1'b0;
      send(100, 200, 16'h4000, 16'h4000, 1'b0);
      send(300, 400, 16'h4000, 16'h4000, 1'b0);
      send(500, 600, 16'h4000, 16'h4000, 1'b0);
      chk("pre_flush_vld", ifc.dout_valid, 1);
      enable = 1'b0;
      cyc();
      chk("flush_vld", ifc.dout_valid, 0);
      chk("flush_dout", ifc.dout, 0);
      enable = 1'b1;
      ifc.dout_ready = 1'b1;
      repeat (3) cyc();
      chk("flush_no_ghost", ifc.dout_valid, 0);

      // Asynchronous reset between clock edges.
      ifc.dout_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ifc.dry_din = 16'($urandom);
         ifc.wet_din = 16'($urandom);
         ifc.dry_din_valid = 1'b1;
         ifc.wet_din_valid = 1'b1;
         cyc();
      end
      ifc.dry_din_valid = 1'b0;
      ifc.wet_din_valid = 1'b0;
      chk("pre_rst_vld", ifc.dout_valid, 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_rst_vld", ifc.dout_valid, 0);
      chk("async_rst_dout", ifc.dout, 0);
      sb.delete();
      sat_model = 0;
      ifc.dout_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      cyc();

      // Bypass passes the raw dry sample.
      send(-5, 900, 16'h1234, 16'hFFFF, 1'b1);
      drain();
      chk("bypass", last_dout, -5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
